// File: rtl/dma_dev_client.sv
// dma_dev_client: device-side DMA requester with a local circular word buffer,
// one request per host command, dev_ack/dma_ack word streaming and timeout abort.
module dma_dev_client #(
    parameter int ADD_LEN  = 16,
    parameter int DATA_LEN = 16,
    parameter int BUF_AW   = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_start,
    input  logic                cmd_rd_wr,
    input  logic [ADD_LEN:0]    cmd_addr,
    input  logic [ADD_LEN-1:0]  cmd_words,
    output logic                busy,
    output logic                done,
    output logic                error,
    input  logic                loc_wr_en,
    input  logic [DATA_LEN-1:0] loc_wdata,
    input  logic                loc_rd_en,
    output logic [DATA_LEN-1:0] loc_rdata,
    output logic [BUF_AW:0]     loc_count,
    input  logic                loc_clear,
    output logic [ADD_LEN-1:0]  num_words,
    output logic [ADD_LEN:0]    start_addr,
    output logic                rd_wr,
    output logic                rqst,
    output logic                dev_ack,
    output logic [DATA_LEN-1:0] dev_in,
    input  logic                dma_ack,
    input  logic [DATA_LEN-1:0] dev_out,
    input  logic                end_flag
);
    localparam int DEPTH = 1 << BUF_AW;
    localparam logic [BUF_AW:0] FULL = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [ADD_LEN:0] DEPTH_X = {{(ADD_LEN-BUF_AW){1'b0}}, FULL};
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ0, REQ1, XFER, WAIT_END, DONE, ERR} state_t;

    state_t state, state_n;
    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [BUF_AW-1:0] wr_ptr, rd_ptr;
    logic [BUF_AW:0] count;
    logic [ADD_LEN-1:0] remaining;
    logic [9:0] tmo;
    logic rej, idle, active, hs, push, pop, clr, bad, accept, tmo_hit;
    logic [ADD_LEN:0] words_x, cnt_x;
    logic [DATA_LEN-1:0] push_data;

    always_comb begin
        idle      = state == IDLE;
        active    = state == REQ0 || state == REQ1 || state == XFER || state == WAIT_END;
        dev_ack   = state == XFER && remaining != '0;
        hs        = dev_ack && dma_ack;
        words_x   = {1'b0, cmd_words};
        cnt_x     = {{(ADD_LEN-BUF_AW){1'b0}}, count};
        bad       = cmd_words == '0 || words_x > DEPTH_X ||
                    (cmd_rd_wr ? words_x > DEPTH_X - cnt_x : words_x > cnt_x);
        accept    = idle && cmd_start && !bad;
        clr       = idle && loc_clear;
        push      = idle ? (!loc_clear && loc_wr_en && count != FULL) : (hs && rd_wr);
        pop       = idle ? (!loc_clear && loc_rd_en && count != '0) : (hs && !rd_wr);
        push_data = idle ? loc_wdata : dev_out;
        tmo_hit   = active && !(dma_ack || end_flag) && tmo == TMO_LAST;
        busy      = !idle;
        done      = state == DONE;
        error     = rej || state == ERR;
        rqst      = state == REQ0 || state == REQ1;
        loc_rdata = mem[rd_ptr];
        loc_count = count;
        dev_in    = (state == XFER && !rd_wr) ? mem[rd_ptr] : '0;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = accept ? REQ0 : IDLE;
            REQ0:     state_n = REQ1;
            REQ1:     state_n = XFER;
            XFER:     state_n = end_flag ? DONE : (hs && remaining == ADD_LEN'(1)) ? WAIT_END : XFER;
            WAIT_END: state_n = end_flag ? DONE : WAIT_END;
            default:  state_n = IDLE;
        endcase
        if (tmo_hit) state_n = ERR;
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= push_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            remaining  <= '0;
            tmo        <= '0;
            rej        <= 1'b0;
            num_words  <= '0;
            start_addr <= '0;
            rd_wr      <= 1'b0;
        end else begin
            state  <= state_n;
            rej    <= idle && cmd_start && bad;
            wr_ptr <= clr ? '0 : wr_ptr + BUF_AW'(push);
            rd_ptr <= clr ? '0 : rd_ptr + BUF_AW'(pop);
            count  <= clr ? '0 : count + (BUF_AW+1)'(push) - (BUF_AW+1)'(pop);
            tmo    <= active ? ((dma_ack || end_flag) ? '0 : tmo + 10'd1) : '0;
            if (accept) begin
                remaining  <= cmd_words;
                num_words  <= cmd_words;
                start_addr <= cmd_addr;
                rd_wr      <= cmd_rd_wr;
            end else if (hs) begin
                remaining <= remaining - ADD_LEN'(1);
            end
        end
    end
endmodule

// File: tb/tb_dma_dev_client.sv
// tb_dma_dev_client: table-driven idle-mode checks plus directed transfer sequences.
module tb_dma_dev_client;
    logic clk, reset, cmd_start, cmd_rd_wr, busy, done, error;
    logic [16:0] cmd_addr, start_addr;
    logic [15:0] cmd_words, loc_wdata, loc_rdata, num_words, dev_in, dev_out;
    logic loc_wr_en, loc_rd_en, loc_clear, rd_wr, rqst, dev_ack, dma_ack, end_flag;
    logic [4:0] loc_count;
    int tests = 0, fails = 0;
    logic [15:0] dat [16];

    dma_dev_client dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_rd_wr(cmd_rd_wr),
        .cmd_addr(cmd_addr), .cmd_words(cmd_words), .busy(busy), .done(done),
        .error(error), .loc_wr_en(loc_wr_en), .loc_wdata(loc_wdata),
        .loc_rd_en(loc_rd_en), .loc_rdata(loc_rdata), .loc_count(loc_count),
        .loc_clear(loc_clear), .num_words(num_words), .start_addr(start_addr),
        .rd_wr(rd_wr), .rqst(rqst), .dev_ack(dev_ack), .dev_in(dev_in),
        .dma_ack(dma_ack), .dev_out(dev_out), .end_flag(end_flag)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic wr, rd, clr, start, rdwr;
        logic [15:0] words, wdata;
        logic e_err;
        logic [4:0] e_cnt;
        logic chk_rd;
        logic [15:0] e_rd;
    } vec_t;
    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] v);
        loc_wr_en = 1; loc_wdata = v;
        @(negedge clk);
        loc_wr_en = 0;
    endtask

    task automatic pop();
        loc_rd_en = 1;
        @(negedge clk);
        loc_rd_en = 0;
    endtask

    task automatic run_cmd(input logic rw, input logic [16:0] a, input logic [15:0] w);
        cmd_start = 1; cmd_rd_wr = rw; cmd_addr = a; cmd_words = w;
        @(negedge clk);
        cmd_start = 0;
        chk("rqst_req0", rqst, 1);
        chk("busy_req0", busy, 1);
        chk("num_words", num_words, w);
        chk("start_addr", start_addr, a);
        chk("rd_wr", rd_wr, rw);
        chk("dev_ack_req0", dev_ack, 0);
        @(negedge clk);
        chk("rqst_req1", rqst, 1);
        @(negedge clk);
        chk("rqst_off", rqst, 0);
        chk("dev_ack_on", dev_ack, 1);
    endtask

    task automatic acks(input int n, input int gap, input logic wr);
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge clk);
            chk("dev_ack_word", dev_ack, 1);
            if (wr) chk("dev_in", dev_in, dat[i]);
            dma_ack = 1; dev_out = wr ? 16'h0 : dat[i];
            @(negedge clk);
            dma_ack = 0;
        end
    endtask

    task automatic end_and_done();
        end_flag = 1;
        @(negedge clk);
        end_flag = 0;
        chk("done_pulse", done, 1);
        chk("error_at_done", error, 0);
        @(negedge clk);
        chk("done_off", done, 0);
        chk("busy_off", busy, 0);
    endtask

    initial begin
        int cyc;
        reset = 0; cmd_start = 0; cmd_rd_wr = 0; cmd_addr = 0; cmd_words = 0;
        loc_wr_en = 0; loc_wdata = 0; loc_rd_en = 0; loc_clear = 0;
        dma_ack = 0; dev_out = 0; end_flag = 0;
        //      wr rd clr st rw words   wdata     err cnt chk rd
        vt[0]  = '{1, 0, 0, 0, 0, 16'd0,  16'h1111, 0, 1, 1, 16'h1111};
        vt[1]  = '{1, 0, 0, 0, 0, 16'd0,  16'h2222, 0, 2, 1, 16'h1111};
        vt[2]  = '{0, 0, 0, 1, 0, 16'd0,  16'h0,    1, 2, 1, 16'h1111};
        vt[3]  = '{0, 0, 0, 1, 0, 16'd17, 16'h0,    1, 2, 1, 16'h1111};
        vt[4]  = '{0, 0, 0, 1, 0, 16'd5,  16'h0,    1, 2, 1, 16'h1111};
        vt[5]  = '{0, 0, 0, 1, 1, 16'd15, 16'h0,    1, 2, 1, 16'h1111};
        vt[6]  = '{0, 0, 0, 1, 0, 16'd3,  16'h0,    1, 2, 1, 16'h1111};
        vt[7]  = '{0, 1, 0, 0, 0, 16'd0,  16'h0,    0, 1, 1, 16'h2222};
        vt[8]  = '{1, 1, 0, 0, 0, 16'd0,  16'h3333, 0, 1, 1, 16'h3333};
        vt[9]  = '{0, 1, 0, 0, 0, 16'd0,  16'h0,    0, 0, 0, 16'h0};
        vt[10] = '{0, 1, 0, 0, 0, 16'd0,  16'h0,    0, 0, 0, 16'h0};
        vt[11] = '{1, 0, 1, 0, 0, 16'd0,  16'h4444, 0, 0, 0, 16'h0};
        vt[12] = '{1, 0, 0, 0, 0, 16'd0,  16'h5555, 0, 1, 1, 16'h5555};

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rqst", rqst, 0);
        chk("rst_dev_ack", dev_ack, 0);
        chk("rst_dev_in", dev_in, 0);
        chk("rst_count", loc_count, 0);
        chk("rst_num_words", num_words, 0);
        chk("rst_start_addr", start_addr, 0);
        chk("rst_rd_wr", rd_wr, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            loc_wr_en = vt[i].wr; loc_rd_en = vt[i].rd; loc_clear = vt[i].clr;
            cmd_start = vt[i].start; cmd_rd_wr = vt[i].rdwr;
            cmd_words = vt[i].words; loc_wdata = vt[i].wdata;
            @(negedge clk);
            loc_wr_en = 0; loc_rd_en = 0; loc_clear = 0; cmd_start = 0;
            chk($sformatf("vec%0d_error", i), error, vt[i].e_err);
            chk($sformatf("vec%0d_count", i), loc_count, vt[i].e_cnt);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            chk($sformatf("vec%0d_rqst", i), rqst, 0);
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), loc_rdata, vt[i].e_rd);
        end

        // full buffer drops the 17th push and rejects any read
        do_reset();
        for (int i = 0; i < 17; i++) push(16'h0A00 + 16'(i));
        chk("full_count", loc_count, 16);
        chk("full_rdata", loc_rdata, 16'h0A00);
        cmd_start = 1; cmd_rd_wr = 1; cmd_words = 1;
        @(negedge clk);
        cmd_start = 0;
        chk("full_read_err", error, 1);
        chk("full_read_busy", busy, 0);

        // write 4 words back-to-back
        do_reset();
        dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333; dat[3] = 16'h4444;
        for (int i = 0; i < 4; i++) push(dat[i]);
        chk("wr_count_pre", loc_count, 4);
        run_cmd(0, 17'h0200, 16'd4);
        acks(4, 0, 1);
        chk("wr_dev_ack_drop", dev_ack, 0);
        chk("wr_count_post", loc_count, 0);
        end_and_done();

        // read 3 words with 2-cycle gaps
        do_reset();
        dat[0] = 16'hAAAA; dat[1] = 16'hBBBB; dat[2] = 16'hCCCC;
        run_cmd(1, 17'h0100, 16'd3);
        acks(3, 2, 0);
        chk("rd_dev_ack_drop", dev_ack, 0);
        chk("rd_count", loc_count, 3);
        end_and_done();
        chk("rd_word0", loc_rdata, 16'hAAAA);
        pop();
        chk("rd_word1", loc_rdata, 16'hBBBB);
        pop();
        chk("rd_word2", loc_rdata, 16'hCCCC);

        // timeout with local port and cmd_start hammered while busy
        do_reset();
        push(16'h0101); push(16'h0202);
        run_cmd(1, 17'h0300, 16'd4);
        loc_clear = 1; loc_wr_en = 1; cmd_start = 1; cmd_words = 1; cmd_rd_wr = 1;
        cyc = 2;
        while (!error && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        loc_clear = 0; loc_wr_en = 0; cmd_start = 0;
        chk("tmo_cycles", cyc, 1023);
        chk("tmo_busy_in_err", busy, 1);
        chk("tmo_dev_ack_in_err", dev_ack, 0);
        @(negedge clk);
        chk("tmo_error_off", error, 0);
        chk("tmo_busy_off", busy, 0);
        chk("tmo_count", loc_count, 2);

        // wrap around DEPTH with early end after 5 of 8 words
        do_reset();
        for (int i = 0; i < 12; i++) push(16'h0);
        for (int i = 0; i < 12; i++) pop();
        for (int i = 0; i < 8; i++) begin
            dat[i] = 16'h5000 + 16'(i);
            push(dat[i]);
        end
        chk("wrap_count_pre", loc_count, 8);
        run_cmd(0, 17'h0400, 16'd8);
        acks(5, 0, 1);
        chk("wrap_dev_ack_still", dev_ack, 1);
        chk("wrap_count_mid", loc_count, 3);
        end_and_done();
        chk("wrap_count_post", loc_count, 3);
        chk("wrap_rdata", loc_rdata, 16'h5005);

        // asynchronous reset mid-transfer
        do_reset();
        for (int i = 0; i < 4; i++) push(16'h7000 + 16'(i));
        for (int i = 0; i < 4; i++) dat[i] = 16'h7000 + 16'(i);
        run_cmd(0, 17'h0500, 16'd4);
        acks(1, 0, 1);
        reset = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rqst", rqst, 0);
        chk("arst_dev_ack", dev_ack, 0);
        chk("arst_dev_in", dev_in, 0);
        chk("arst_num_words", num_words, 0);
        chk("arst_start_addr", start_addr, 0);
        chk("arst_count", loc_count, 0);
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_done", done, 0);
            chk("arst_no_error", error, 0);
        end
        chk("arst_count_after", loc_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dma_dev_client.md
Name: dma_dev_client

Overview:
- Device-side requester that sits directly upstream of the DMA controller's device interface.
- Holds a local word buffer that the peripheral fills or drains through a simple local port.
- On a host command it issues one DMA request (num_words, start_addr, rd_wr, rqst), then streams words with the dev_ack/dma_ack handshake until end_flag.
- Reports done/error to the host.

Parameters:
- ADD_LEN, 16, address/word-count width; start_addr is ADD_LEN+1 bits (byte address).
- DATA_LEN, 16, data word width.
- BUF_AW, 4, log2 of local buffer depth; DEPTH = 2^BUF_AW words.
- TIMEOUT, 1023, idle cycles tolerated while BUSY before abort; counter width 10.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle transfer request, honoured only in IDLE.
- cmd_rd_wr  in  1  1: memory->buffer (read), 0: buffer->memory (write).
- cmd_addr  in  ADD_LEN+1  byte start address.
- cmd_words  in  ADD_LEN  word count.
- busy  out  1  high from accepted cmd_start until DONE/ERR exit.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on rejected command or timeout.
- loc_wr_en  in  1  push loc_wdata into buffer (ignored while busy).
- loc_wdata  in  DATA_LEN  local write data.
- loc_rd_en  in  1  pop buffer head (ignored while busy).
- loc_rdata  out  DATA_LEN  buffer head, combinational.
- loc_count  out  BUF_AW+1  words currently held.
- loc_clear  in  1  empty buffer (IDLE only).
- num_words  out  ADD_LEN  to controller.
- start_addr  out  ADD_LEN+1  to controller.
- rd_wr  out  1  to controller.
- rqst  out  1  to controller.
- dev_ack  out  1  device-ready strobe to controller.
- dev_in  out  DATA_LEN  data to controller (write direction).
- dma_ack  in  1  controller word strobe.
- dev_out  in  DATA_LEN  data from controller (read direction).
- end_flag  in  1  controller end-of-transfer pulse.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; buffer pointers and count are 0.
  - All outputs are 0, except loc_rdata, which shows the contents of buffer[0].
- Buffer:
  - Circular, with wr_ptr, rd_ptr and count; pointers wrap modulo DEPTH.
  - In IDLE: loc_wr_en pushes when count<DEPTH, otherwise it is dropped. loc_rd_en pops when count>0, otherwise it is ignored. A simultaneous push and pop leaves count unchanged. loc_clear has priority over both.
- Command check in IDLE on cmd_start:
  - Reject with an error pulse and stay IDLE if cmd_words==0 or cmd_words>DEPTH.
  - Read: also reject if cmd_words > DEPTH-count.
  - Write: also reject if cmd_words > count.
- The accepted command is registered. num_words, start_addr and rd_wr are driven from these registers and held stable until IDLE is re-entered.
- FSM states: IDLE, REQ0, REQ1, XFER, WAIT_END, DONE, ERR.
  - IDLE -> REQ0 on a valid cmd_start.
  - REQ0, REQ1: rqst=1 for exactly two cycles so the controller samples the operands in its register-load cycle.
  - REQ1 -> XFER.
  - XFER, write direction:
    - dev_in = buffer[rd_ptr].
    - dev_ack=1 while remaining>0.
    - On each cycle with dma_ack=1 and dev_ack=1: pop and decrement remaining.
  - XFER, read direction:
    - dev_ack=1 while remaining>0.
    - On each cycle with dma_ack=1 and dev_ack=1: push dev_out and decrement remaining.
  - XFER -> WAIT_END when remaining reaches 0; dev_ack drops in that same cycle.
  - end_flag seen in XFER or WAIT_END -> DONE, even if remaining>0 (early end; remaining is discarded).
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: error=1 for one cycle; rqst and dev_ack=0 -> IDLE. Buffer contents are kept.
- Timeout:
  - Counter clears on any dma_ack or end_flag and increments otherwise while in REQ0..WAIT_END.
  - On reaching TIMEOUT -> ERR.
- cmd_start, loc_wr_en, loc_rd_en and loc_clear are ignored while busy.
- Reset asserted mid-transfer aborts immediately to IDLE; no done or error pulse is produced.
- Latency: first dev_ack is asserted 2 cycles after cmd_start acceptance; done follows end_flag by 1 cycle.

Test Plan:
- Fill 4 words 0x1111..0x4444; cmd_start write, addr=0x0200, words=4 -> rqst high for 2 cycles with num_words=4, start_addr=0x0200, rd_wr=0. dev_in presents 0x1111..0x4444 on successive dma_ack cycles; loc_count goes 4->0. end_flag -> done pulse 1 cycle later.
- Empty buffer; read, words=3; model returns 0xAAAA, 0xBBBB, 0xCCCC with dma_ack gaps of 2 cycles -> buffer holds those values in order, dev_ack drops after the third word, done after end_flag.
- cmd_words=0, then cmd_words=DEPTH+1, then a write with words=5 and count=2 -> error pulse each time, rqst never asserted, busy stays 0.
- Read with words=4; model never asserts dma_ack -> error pulse exactly TIMEOUT cycles after last activity, state IDLE, loc_count unchanged.
- Write of 8 words with buffer start offset 12 (DEPTH=16) -> pointers wrap correctly and data order is preserved; end_flag after 5 words -> done, loc_count=3.
- Pull reset low during XFER -> all outputs 0 asynchronously, no done or error pulse, loc_count=0 after release.
